// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time/duty measurement with brightness index and stuck-line timeout
module pwm_capture #(
  parameter int CNT_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] period_cnt,
  output logic [CNT_WIDTH-1:0] high_cnt,
  output logic [6:0]           duty_pct,
  output logic [3:0]           duty_index,
  output logic                 meas_valid,
  output logic                 stuck,
  output logic                 overrun
);

  localparam int DIV_CYCLES = CNT_WIDTH + 7;
  localparam int DW         = CNT_WIDTH + 7;
  localparam int IW         = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  logic                 s1, s2, s3;
  logic                 rise, fall;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] hi_lat;
  logic                 timeout;
  state_t               state, state_nxt;
  logic                 latch_hi, capture;

  logic                 div_busy;
  logic [IW-1:0]        div_iter;
  logic [CNT_WIDTH-1:0] div_p, div_h, div_rem;
  logic [DW-1:0]        div_dq;
  logic [CNT_WIDTH:0]   div_trial, div_diff;
  logic                 div_ge, div_last, div_start;
  logic [CNT_WIDTH:0]   rem_nxt;
  logic [DW-1:0]        dq_nxt;
  logic [DW-1:0]        dividend;
  logic [6:0]           quot;

  // Nearest-10 rounding minus one, clamped to 0..8: each threshold 15,25,..,85 adds one step.
  function automatic logic [3:0] to_index(input logic [6:0] q);
    logic [3:0] idx;
    idx = '0;
    for (int k = 1; k <= 8; k++) begin
      if (q >= 7'(10 * k + 5)) idx = 4'(k);
    end
    return idx;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_WIDTH'(1);
    end else if (cnt < TIMEOUT_VAL) begin
      cnt <= cnt + 1'b1;
    end
  end

  // An edge in the same cycle as the saturation point suppresses the timeout.
  assign timeout = (cnt == TIMEOUT_VAL) && !stuck && !rise && !fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_RISE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = WAIT_RISE;
    end else begin
      case (state)
        WAIT_RISE: if (rise) state_nxt = MEAS_HIGH;
        MEAS_HIGH: if (fall) state_nxt = MEAS_LOW;
        MEAS_LOW:  if (rise) state_nxt = MEAS_HIGH;
        default:   state_nxt = WAIT_RISE;
      endcase
    end
  end

  always_comb begin
    latch_hi = 1'b0;
    capture  = 1'b0;
    case (state)
      MEAS_HIGH: latch_hi = fall;
      MEAS_LOW:  capture  = rise;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           hi_lat <= '0;
    else if (latch_hi) hi_lat <= cnt;
  end

  // Restoring division of H*100 by P, one quotient bit per cycle shifted into div_dq.
  assign dividend  = DW'(hi_lat) * DW'(100);
  assign div_trial = {div_rem, div_dq[DW-1]};
  assign div_ge    = div_trial >= {1'b0, div_p};
  assign div_diff  = div_trial - {1'b0, div_p};
  assign rem_nxt   = div_ge ? div_diff : div_trial;
  assign dq_nxt    = {div_dq[DW-2:0], div_ge};
  assign div_last  = div_busy && (div_iter == IW'(DIV_CYCLES - 1));
  assign div_start = capture && !div_busy;
  assign quot      = dq_nxt[6:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy <= 1'b0;
      div_iter <= '0;
      div_p    <= '0;
      div_h    <= '0;
      div_rem  <= '0;
      div_dq   <= '0;
    end else if (div_start) begin
      div_busy <= 1'b1;
      div_iter <= '0;
      div_p    <= cnt;
      div_h    <= hi_lat;
      div_rem  <= '0;
      div_dq   <= dividend;
    end else if (div_busy) begin
      div_rem  <= rem_nxt[CNT_WIDTH-1:0];
      div_dq   <= dq_nxt;
      div_iter <= div_iter + IW'(1);
      if (div_last) div_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      duty_pct   <= '0;
      duty_index <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      overrun    <= capture && div_busy;
      if (timeout) begin
        stuck      <= 1'b1;
        meas_valid <= 1'b1;
        period_cnt <= '0;
        high_cnt   <= '0;
        duty_pct   <= s2 ? 7'd100 : 7'd0;
        duty_index <= s2 ? 4'd8 : 4'd0;
      end else if (div_last) begin
        period_cnt <= div_p;
        high_cnt   <= div_h;
        duty_pct   <= quot;
        duty_index <= to_index(quot);
        meas_valid <= 1'b1;
        stuck      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized bench for pwm_capture against an event-level measurement model
module tb_pwm_capture;

  localparam int CW      = 12;
  localparam int TIMEOUT = 3000;
  localparam int DIV     = CW + 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] period_cnt, high_cnt;
  logic [6:0]    duty_pct;
  logic [3:0]    duty_index;
  logic          meas_valid, stuck, overrun;

  pwm_capture #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period_cnt(period_cnt), .high_cnt(high_cnt), .duty_pct(duty_pct),
    .duty_index(duty_index), .meas_valid(meas_valid), .stuck(stuck), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p; int h; int q; int idx; int cyc; bit stk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ovr_got  = 0;
  int   ovr_exp  = 0;
  bit   have_rise = 0;
  bit   acc_valid = 0;
  int   last_rise, last_fall, last_accept;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t make_meas(input int p, input int h, input int c);
    exp_t e;
    e.p = p; e.h = h; e.q = (h * 100) / p;
    e.idx = (e.q + 5) / 10 - 1;
    if (e.idx < 0) e.idx = 0;
    if (e.idx > 8) e.idx = 8;
    e.cyc = c + 2 + DIV + 1;
    e.stk = 1'b0;
    return e;
  endfunction

  // A rise closes the running period; it is measured only if the divider is free by then.
  task automatic model_rise(input int c);
    if (have_rise) begin
      if (!acc_valid || (c - last_accept) >= DIV + 1) begin
        exp_q.push_back(make_meas(c - last_rise, last_fall - last_rise, c));
        last_accept = c;
        acc_valid   = 1'b1;
      end else begin
        ovr_exp++;
      end
    end
    have_rise = 1'b1;
    last_rise = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set_pwm(input logic v);
    if (v && !pwm_in) model_rise(cyc);
    else if (!v && pwm_in) last_fall = cyc;
    pwm_in = v;
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      tick(); set_pwm(1'b1); hold(h - 1);
      tick(); set_pwm(1'b0); hold(l - 1);
    end
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    expect_eq({tag, "_drain"}, exp_q.size(), 0);
    hold(3);
    expect_eq({tag, "_overruns"}, ovr_got, ovr_exp);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    pwm_in = 1'b0;
    #1;
    expect_eq({tag, "_outputs_zero"},
              {period_cnt, high_cnt, duty_pct, duty_index, meas_valid, stuck, overrun}, 0);
    exp_q.delete();
    have_rise = 1'b0;
    acc_valid = 1'b0;
    hold(4);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ovr_got++;
      if (meas_valid) begin
        expect_eq("valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          expect_eq("period_cnt", period_cnt, e.p);
          expect_eq("high_cnt",   high_cnt,   e.h);
          expect_eq("duty_pct",   duty_pct,   e.q);
          expect_eq("duty_index", duty_index, e.idx);
          expect_eq("stuck",      stuck,      e.stk);
          expect_eq("valid_cycle", cyc,       e.cyc);
        end
      end
    end
  end

  initial begin
    exp_t te;
    hold(3);
    do_reset("reset");
    hold(2);

    wave(250, 250, 4);  settle("d50");
    wave(50, 450, 3);   settle("d10");
    wave(450, 50, 3);   settle("d90");
    wave(20, 480, 3);   settle("d4");
    wave(480, 20, 3);   settle("d96");
    wave(333, 167, 3);  settle("d66");
    wave(5, 5, 12);     settle("overrun");
    expect_eq("overrun_seen", ovr_got > 0, 1);

    for (int r = 0; r < 8; r++) begin
      int h, l;
      h = $urandom_range(600, 1);
      l = $urandom_range(600, 1);
      wave(h, l, 2);
    end
    settle("random");

    // Line held high after a valid period: one timeout report, then silence.
    wave(250, 250, 2);
    tick(); set_pwm(1'b1);
    te.p = 0; te.h = 0; te.q = 100; te.idx = 8; te.stk = 1'b1;
    te.cyc = cyc + 2 + TIMEOUT + 1;
    exp_q.push_back(te);
    have_rise = 1'b0;
    hold(TIMEOUT + 60);
    expect_eq("stuck_held", stuck, 1);
    tick(); set_pwm(1'b0); hold(30);
    expect_eq("stuck_before_resume", stuck, 1);
    wave(250, 250, 3);  settle("resume");
    expect_eq("stuck_cleared", stuck, 0);

    wave(200, 200, 2);
    tick(); set_pwm(1'b1); hold(50);
    do_reset("rst_mid_high");
    wave(300, 200, 3);  settle("after_rst_high");

    wave(100, 100, 2);
    tick(); set_pwm(1'b1); hold(5);
    do_reset("rst_mid_div");
    wave(150, 350, 3);  settle("after_rst_div");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
